// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the adder_arbiter round-robin adder sequencer.
package adder_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_REQ = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping past N-1.
module rr_pick
  import adder_arbiter_pkg::*;
#(
  parameter int N   = DEF_N_REQ,
  parameter int IDW = clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic [2*N-1:0] dbl;
  logic           found;

  // The upper copy of the request vector supplies the wrapped-around candidates.
  assign dbl = {req, req};
  assign any = |req;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int j = 0; j < 2*N; j++) begin
      if (!found && dbl[j] && (j >= int'(ptr))) begin
        found = 1'b1;
        idx   = IDW'(j % N);
      end
    end
    if (found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one external combinational adder among N_REQ requesters using a
// three-state accept/execute/respond sequence with round-robin arbitration.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  localparam int IDW  = clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  input  logic [WIDTH-1:0]       add_y,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_ovf,
  output logic [IDW-1:0]         rsp_id
);

  // Handshakes: a transfer happens on the rising edge where valid and ready are
  // both high. req_ready is a one-cycle accept pulse raised only in IDLE;
  // rsp_valid stays high in RESP until rsp_ready, with outputs held stable.

  state_t           state, state_n;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   win_idx;
  logic [N_REQ-1:0] win_grant;
  logic             win_any;
  logic             accept;
  logic [WIDTH-1:0] op_a, op_b;

  rr_pick #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  always_comb begin
    state_n   = state;
    req_ready = '0;
    accept    = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (win_any) begin
          req_ready = win_grant;
          accept    = 1'b1;
          state_n   = EXEC;
        end
      end
      EXEC: state_n = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      id_q    <= '0;
      op_a    <= '0;
      op_b    <= '0;
      rsp_sum <= '0;
      rsp_ovf <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_a <= req_a[int'(win_idx)*WIDTH +: WIDTH];
        op_b <= req_b[int'(win_idx)*WIDTH +: WIDTH];
        id_q <= win_idx;
      end
      // A wrapped sum is smaller than either operand, which gives the carry-out.
      if (state == EXEC) begin
        rsp_sum <= add_y;
        rsp_ovf <= (add_y < op_a);
      end
      if (state == RESP && rsp_ready)
        ptr <= (int'(id_q) == N_REQ-1) ? '0 : id_q + IDW'(1);
    end
  end

  assign add_a  = op_a;
  assign add_b  = op_b;
  assign rsp_id = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: vector table, round-robin model and
// response scoreboard, plus directed backpressure, wrap and reset sequences.
`timescale 1ns/1ps
module tb_adder_arbiter;
  import adder_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = clog2(N);
  localparam int SBW = IDW + 1 + W;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   add_a, add_b, add_y;
  logic           rsp_valid, rsp_ready, rsp_ovf;
  logic [W-1:0]   rsp_sum;
  logic [IDW-1:0] rsp_id;

  logic [N-1:0] rv = '0;
  logic [W-1:0] ra [N];
  logic [W-1:0] rb [N];
  int           left [N];

  int n_checks = 0;
  int n_err    = 0;
  logic [SBW-1:0] exp_q[$];
  int id_log[$];
  int m_phase = 0;
  int m_ptr   = 0;
  int m_id    = 0;
  logic acc_flag = 1'b0;
  int   acc_w = 0;

  logic [N-1:0] prev_rv = '0, prev_rdy = '0;
  logic [W-1:0] prev_ra [N];
  logic [W-1:0] prev_rb [N];

  typedef struct {
    int         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic       ovf;
  } vec_t;
  vec_t vecs [6];

  // ---------------- clock / reset / external adder ----------------
  always #5 clk = ~clk;
  assign add_y     = add_a + add_b;
  assign req_valid = rv;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = ra[i];
      req_b[i*W +: W] = rb[i];
    end
  end

  adder_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_y     (add_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_ovf   (rsp_ovf),
    .rsp_id    (rsp_id)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_model(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // ---------------- reference model + scoreboard (negedge) ----------------
  always @(negedge clk) begin : monitor
    logic [N-1:0] exp_ready;
    logic [W:0]   full;
    int           w;
    if (!rst_n) begin
      m_phase = 0;
      m_ptr   = 0;
      acc_flag = 1'b0;
      exp_q.delete();
      prev_rv = '0;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 0);
    end else begin
      for (int i = 0; i < N; i++)
        if (prev_rv[i] && !prev_rdy[i])
          assert (rv[i] && ra[i] == prev_ra[i] && rb[i] == prev_rb[i])
            else $error("requester %0d dropped or changed a pending request", i);
      exp_ready = '0;
      w = -1;
      if (m_phase == 0 && rv != '0) begin
        w = rr_model(rv, m_ptr);
        exp_ready[w] = 1'b1;
      end
      check("req_ready", req_ready, exp_ready);
      check("rsp_valid", rsp_valid, m_phase == 2);
      if (m_phase == 2) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else check("rsp_data", {rsp_id, rsp_ovf, rsp_sum}, exp_q[0]);
      end
      case (m_phase)
        0: if (w >= 0) begin
             full = {1'b0, ra[w]} + {1'b0, rb[w]};
             exp_q.push_back({IDW'(w), full});
             m_id = w;
             acc_w = w;
             acc_flag = 1'b1;
             m_phase = 1;
           end
        1: m_phase = 2;
        default: if (rsp_ready) begin
             if (exp_q.size() > 0) void'(exp_q.pop_front());
             id_log.push_back(int'(rsp_id));
             m_ptr = (m_id + 1) % N;
             m_phase = 0;
           end
      endcase
      prev_rv  = rv;
      prev_rdy = req_ready;
      for (int i = 0; i < N; i++) begin
        prev_ra[i] = ra[i];
        prev_rb[i] = rb[i];
      end
    end
  end

  // ---------------- requester driver: reload or drop after an accept ----------------
  always @(posedge clk) begin
    #1;
    if (acc_flag) begin
      acc_flag = 1'b0;
      if (left[acc_w] > 0) begin
        left[acc_w]--;
        ra[acc_w] = W'($urandom_range(0, (1 << W) - 1));
        rb[acc_w] = W'($urandom_range(0, (1 << W) - 1));
      end else begin
        rv[acc_w] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic raise(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input int n_more);
    ra[i]   = a;
    rb[i]   = b;
    left[i] = n_more;
    rv[i]   = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while (!(rv == '0 && m_phase == 0 && exp_q.size() == 0) && c < budget) begin
      tick();
      c++;
    end
    if (!(rv == '0 && m_phase == 0 && exp_q.size() == 0)) check("drain_timeout", 1, 0);
  endtask

  task automatic wait_rsp(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid && cyc < budget);
    if (!rsp_valid) check("rsp_timeout", 1, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rv    = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int cyc;
    vecs[0] = '{2, 8'h12, 8'h34, 8'h46, 1'b0};
    vecs[1] = '{0, 8'hF0, 8'h20, 8'h10, 1'b1};
    vecs[2] = '{1, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[3] = '{3, 8'h7F, 8'h80, 8'hFF, 1'b0};
    vecs[4] = '{2, 8'h80, 8'h80, 8'h00, 1'b1};
    vecs[5] = '{1, 8'h00, 8'h00, 8'h00, 1'b0};
    for (int i = 0; i < N; i++) begin
      ra[i] = '0;
      rb[i] = '0;
      left[i] = 0;
    end
    rsp_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("reset_sum", rsp_sum, 0);
    check("reset_ovf", rsp_ovf, 0);
    check("reset_id", rsp_id, 0);
    check("reset_add_a", add_a, 0);
    check("reset_add_b", add_b, 0);
    tick();
    rst_n = 1'b1;

    // Single-request vectors
    for (int v = 0; v < 6; v++) begin
      raise(vecs[v].id, vecs[v].a, vecs[v].b, 0);
      wait_rsp(10, cyc);
      check("vec_latency", cyc, 3);
      check("vec_sum", rsp_sum, vecs[v].sum);
      check("vec_ovf", rsp_ovf, vecs[v].ovf);
      check("vec_id", rsp_id, vecs[v].id);
      tick();
      wait_drain(10);
    end

    // Fairness: all four held valid for 12 operations from ptr 0
    do_reset();
    id_log.delete();
    for (int i = 0; i < N; i++)
      raise(i, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 2);
    wait_drain(100);
    check("fair_count", id_log.size(), 12);
    for (int k = 0; k < 12 && k < id_log.size(); k++)
      check("fair_id", id_log[k], k % N);

    // Backpressure: hold RESP for 10 cycles while req 2 arrives
    rsp_ready = 1'b0;
    raise(1, 8'h21, 8'h43, 0);
    wait_rsp(10, cyc);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 2) raise(2, 8'h05, 8'h06, 0);
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_sum", rsp_sum, 8'h64);
      check("bp_id", rsp_id, 1);
      check("bp_ready", req_ready, 0);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", req_ready, 0);
    @(negedge clk);
    check("bp_next_accept", req_ready, 4'b0100);
    tick();
    wait_drain(10);

    // Wrap and skip: ptr is 3, only req 1 valid, then 0 and 3 together
    id_log.delete();
    raise(1, 8'hC0, 8'h50, 0);
    wait_drain(10);
    raise(0, 8'h01, 8'h02, 0);
    raise(3, 8'h0A, 8'h0B, 0);
    wait_drain(20);
    check("wrap_count", id_log.size(), 3);
    if (id_log.size() == 3) begin
      check("wrap_first", id_log[0], 1);
      check("wrap_second", id_log[1], 3);
      check("wrap_third", id_log[2], 0);
    end

    // Reset in EXEC, then req 0 and 3 together must grant 0
    raise(2, 8'h11, 8'h22, 0);
    @(negedge clk);
    tick();
    rst_n = 1'b0;
    rv    = '0;
    #1;
    check("rst_exec_valid", rsp_valid, 0);
    check("rst_exec_sum", rsp_sum, 0);
    tick();
    tick();
    rst_n = 1'b1;
    id_log.delete();
    raise(0, 8'h30, 8'h40, 0);
    raise(3, 8'h50, 8'h60, 0);
    wait_drain(20);
    check("rst_exec_count", id_log.size(), 2);
    if (id_log.size() == 2) begin
      check("rst_exec_first", id_log[0], 0);
      check("rst_exec_second", id_log[1], 3);
    end

    // Reset in RESP drops rsp_valid at once; nothing is re-issued afterwards
    rsp_ready = 1'b0;
    raise(1, 8'h33, 8'h44, 0);
    wait_rsp(10, cyc);
    #2;
    rst_n = 1'b0;
    rv    = '0;
    #1;
    check("rst_resp_valid", rsp_valid, 0);
    check("rst_resp_id", rsp_id, 0);
    tick();
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one combinational WIDTH-bit adder among N_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block latches the winning pair, drives the shared adder, registers the sum with a wrap flag, and returns it on a single response channel tagged with the requester id. It sits between the requesting engines and the single `adder` datapath instance, which is external to this block.

## Interface
- `N_REQ`, default 4: number of requesters; must be at least 2.
- `WIDTH`, default 8: operand and sum width; must match the shared adder.
- `clk` in 1: the only clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: per-requester request valid.
- `req_a` in N_REQ*WIDTH: operand A, packed; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b` in N_REQ*WIDTH: operand B, packed the same way.
- `req_ready` out N_REQ: one-hot accept pulse.
- `add_a` out WIDTH: operand A driven to the shared adder.
- `add_b` out WIDTH: operand B driven to the shared adder.
- `add_y` in WIDTH: sum returned from the shared adder (combinational).
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_sum` out WIDTH: registered sum, modulo 2^WIDTH.
- `rsp_ovf` out 1: set when the true sum is 2^WIDTH or more.
- `rsp_id` out clog2(N_REQ): index of the requester that owns the response.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `req_valid` is high, pick winner w by round-robin, searching from `ptr` upward with wrap.
  - Assert `req_ready[w]` combinationally in this cycle.
  - At the clock edge, latch `req_a[w]` and `req_b[w]` into the operand registers and w into the id register, then go to EXEC.
  - If no request is valid, stay in IDLE.
- **EXEC**
  - `add_a`/`add_b` come from the operand registers, which hold their value in every state.
  - At the edge, `rsp_sum` <= `add_y` and `rsp_ovf` <= (`add_y` < `add_a`).
  - Go to RESP.
- **RESP**
  - `rsp_valid` = 1.
  - When `rsp_ready` is high, `ptr` <= (w+1) mod N_REQ and go to IDLE.
  - Otherwise hold all response outputs stable.
- Requester rule: once `req_valid[i]` is raised it holds, with stable operands, until `req_ready[i]`. The bench asserts this; the RTL does not depend on it.
- No new request is accepted outside IDLE. `req_ready` is all-zero in EXEC and RESP.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0. No requester waits more than N_REQ-1 grants.

## Timing
- Reset values: state IDLE, `ptr` 0, operand registers 0, `add_a`/`add_b` 0, `rsp_valid` 0, `rsp_sum` 0, `rsp_ovf` 0, `rsp_id` 0, `req_ready` 0.
- Latency: accept edge at cycle T, sum captured at edge T+1, `rsp_valid` high during cycle T+2.
- Throughput: at most one operation per 3 cycles when `rsp_ready` is tied high.
- Backpressure: `rsp_ready` low holds RESP indefinitely, and outputs stay stable.
- Response handshake completes on the edge where `rsp_valid` and `rsp_ready` are both high. The next accept can occur in the following IDLE cycle at the earliest.
- Wrap: `ptr` = N_REQ-1 followed by a grant wraps to 0. The search wraps past index N_REQ-1.
- Simultaneous events: a `req_valid` rising in RESP is not seen until IDLE. A request and `rsp_ready` in the same RESP cycle produce no accept in that cycle.
- Reset mid-operation: asserting `rst_n` low in EXEC or RESP immediately drops `rsp_valid` and returns to IDLE with `ptr` 0. The in-flight result is discarded and never re-issued.
- Adder path: `add_a`/`add_b` to `add_y` is one combinational cycle and must meet the single-cycle budget.

## Structure
- Package `adder_arbiter_pkg` holds:
  - the state enum {IDLE, EXEC, RESP};
  - the default WIDTH and N_REQ constants;
  - the id-width function clog2.
- Sub-module `rr_pick`, parameterized by N:
  - inputs: request vector and `ptr`;
  - outputs: one-hot grant, grant index, and any-valid.
  - It is purely combinational, implemented as double-width masked priority.
- The top level contains the FSM, operand registers, result registers, and the `ptr` register. The adder itself is not instantiated here.

## Test plan
- Single request: req 2 with A=0x12, B=0x34 → `req_ready`=0b0100 for one cycle; 2 cycles later `rsp_sum`=0x46, `rsp_ovf`=0, `rsp_id`=2.
- Overflow: A=0xF0, B=0x20 → `rsp_sum`=0x10, `rsp_ovf`=1. Also A=0xFF, B=0x01 → `rsp_sum`=0x00, `rsp_ovf`=1.
- Fairness: all 4 requesters held valid for 12 operations → `rsp_id` sequence 0,1,2,3,0,1,2,3,0,1,2,3, and each sum matches its pair.
- Backpressure: `rsp_ready` low for 10 cycles in RESP → `rsp_valid`/`rsp_sum`/`rsp_id` stable, `req_ready` stays 0; releasing it gives the next accept one cycle later.
- Wrap and skip: `ptr`=3, only req 1 valid → grant 1; next grant searches from 2.
- Reset mid-op: assert `rst_n` low in EXEC → `rsp_valid` 0 immediately; after release, req 0 and req 3 both valid → grant 0 (`ptr` reset to 0).
